// File: rtl/led_arbiter.sv
// Round-robin arbiter that grants one requester at a time the green LED bank.
// Tenure is capped at HOLD_CYCLES while others wait; a one-cycle gap follows every release.
module led_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 12_000_000,
    parameter int TW          = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ-1:0]   i_rel,
    input  logic [5*NREQ-1:0] i_pat,
    output logic [NREQ-1:0]   o_gnt,
    output logic [4:0]        o_gleds,
    output logic              o_rled,
    output logic              o_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwned,
        StGap
    } state_e;

    state_e          r_state, w_state_next;
    logic [IW-1:0]   r_owner, w_owner_next;
    logic [IW-1:0]   r_ptr, w_ptr_next;
    logic [TW-1:0]   r_timer, w_timer_next;
    logic [NREQ-1:0] r_gnt, w_gnt_next;
    logic [4:0]      r_gleds, w_gleds_next;
    logic            r_rled, w_rled_next;
    logic            r_busy, w_busy_next;

    logic            w_win_found;
    logic [IW-1:0]   w_win_idx;
    logic [NREQ-1:0] w_win_onehot;
    logic [4:0]      w_owner_pat;
    logic            w_timer_sat;
    logic            w_others_waiting;
    logic            w_exit;
    logic [IW-1:0]   w_owner_inc;

    // First requester at or above r_ptr, wrapping around.
    always_comb begin
        int v_idx;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        v_idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_win_found && i_req[v_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = IW'(v_idx);
            end
        end
    end

    assign w_win_onehot     = NREQ'(1) << w_win_idx;
    assign w_owner_pat      = i_pat[int'(r_owner)*5 +: 5];
    assign w_timer_sat      = (r_timer == HOLD_LAST);
    // r_gnt is the owner's one-hot while OWNED, so masking it leaves the waiters.
    assign w_others_waiting = |(i_req & ~r_gnt);
    assign w_exit           = i_rel[r_owner] | ~i_req[r_owner]
                            | (w_timer_sat & w_others_waiting);
    assign w_owner_inc      = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_ptr;
        w_timer_next = r_timer;
        w_gnt_next   = r_gnt;
        w_gleds_next = r_gleds;

        unique case (r_state)
            StIdle: begin
                w_gnt_next   = '0;
                w_gleds_next = '0;
                if (w_win_found) begin
                    w_state_next = StOwned;
                    w_owner_next = w_win_idx;
                    w_gnt_next   = w_win_onehot;
                    w_timer_next = '0;
                end
            end
            StOwned: begin
                if (w_exit) begin
                    w_state_next = StGap;
                    w_gnt_next   = '0;
                    w_gleds_next = '0;
                    w_ptr_next   = w_owner_inc;
                end else begin
                    w_gleds_next = w_owner_pat;
                    if (!w_timer_sat) begin
                        w_timer_next = r_timer + 1'b1;
                    end
                end
            end
            StGap: begin
                w_state_next = StIdle;
                w_gnt_next   = '0;
                w_gleds_next = '0;
            end
            default: begin
                w_state_next = StIdle;
                w_gnt_next   = '0;
                w_gleds_next = '0;
            end
        endcase

        w_rled_next = |(i_req & ~w_gnt_next);
        w_busy_next = (w_state_next != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_owner <= '0;
            r_ptr   <= '0;
            r_timer <= '0;
            r_gnt   <= '0;
            r_gleds <= '0;
            r_rled  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_ptr   <= w_ptr_next;
            r_timer <= w_timer_next;
            r_gnt   <= w_gnt_next;
            r_gleds <= w_gleds_next;
            r_rled  <= w_rled_next;
            r_busy  <= w_busy_next;
        end
    end

    assign o_gnt   = r_gnt;
    assign o_gleds = r_gleds;
    assign o_rled  = r_rled;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with NREQ=4, HOLD_CYCLES=8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_led_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   rel;
    logic [5*NREQ-1:0] pat;
    logic [NREQ-1:0]   gnt;
    logic [4:0]        gleds;
    logic              rled;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [4:0] PAT0 = 5'h15;
    localparam logic [4:0] PAT1 = 5'h0A;
    localparam logic [4:0] PAT2 = 5'h1F;
    localparam logic [4:0] PAT3 = 5'h03;

    led_arbiter #(
        .NREQ(NREQ),
        .HOLD_CYCLES(8),
        .TW(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(req),
        .i_rel(rel),
        .i_pat(pat),
        .o_gnt(gnt),
        .o_gleds(gleds),
        .o_rled(rled),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"}, 8'(gnt), 8'h0);
        chk({tag, ".gleds"}, 8'(gleds), 8'h0);
        chk({tag, ".rled"}, 8'(rled), 8'h0);
        chk({tag, ".busy"}, 8'(busy), 8'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        rel   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        pat = {PAT3, PAT2, PAT1, PAT0};

        // Reset state, then basic grant / release / regrant.
        do_reset();
        chk_all_zero("reset");
        req = 4'b0101;
        step();
        chk("e1.gnt", 8'(gnt), 8'h01);
        chk("e1.gleds", 8'(gleds), 8'h00);
        chk("e1.rled", 8'(rled), 8'h01);
        chk("e1.busy", 8'(busy), 8'h01);
        step();
        chk("e2.gleds", 8'(gleds), 8'(PAT0));
        step();
        step();
        step();
        rel = 4'b0001;
        req = 4'b0100;
        step();
        rel = '0;
        chk("gap.gnt", 8'(gnt), 8'h00);
        chk("gap.gleds", 8'(gleds), 8'h00);
        chk("gap.busy", 8'(busy), 8'h01);
        chk("gap.rled", 8'(rled), 8'h01);
        step();
        chk("idle.gnt", 8'(gnt), 8'h00);
        chk("idle.busy", 8'(busy), 8'h00);
        step();
        chk("regrant.gnt", 8'(gnt), 8'h04);
        chk("regrant.rled", 8'(rled), 8'h00);
        step();
        chk("regrant.gleds", 8'(gleds), 8'(PAT2));

        // Preemption alternation with req=0011 held.
        do_reset();
        req = 4'b0011;
        for (int k = 1; k <= 21; k++) begin
            step();
            if (k <= 8)       exp_gnt = 4'b0001;
            else if (k <= 10) exp_gnt = 4'b0000;
            else if (k <= 18) exp_gnt = 4'b0010;
            else if (k <= 20) exp_gnt = 4'b0000;
            else              exp_gnt = 4'b0001;
            chk($sformatf("alt.e%0d.gnt", k), 8'(gnt), 8'(exp_gnt));
            chk($sformatf("alt.e%0d.rled", k), 8'(rled), 8'h01);
        end

        // Lone requester keeps the grant; saturated timer preempts at once.
        do_reset();
        req = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("solo.e%0d.gnt", k), 8'(gnt), 8'h01);
            chk($sformatf("solo.e%0d.busy", k), 8'(busy), 8'h01);
        end
        chk("solo.rled", 8'(rled), 8'h00);
        req = 4'b0011;
        step();
        chk("sat.preempt.gnt", 8'(gnt), 8'h00);
        chk("sat.preempt.busy", 8'(busy), 8'h01);

        // Non-owner rel ignored; combined rel+req drop gives one exit, ptr=2.
        do_reset();
        req = 4'b0010;
        step();
        chk("nrel.e1.gnt", 8'(gnt), 8'h02);
        req = 4'b0111;
        step();
        chk("nrel.e2.gnt", 8'(gnt), 8'h02);
        chk("nrel.e2.gleds", 8'(gleds), 8'(PAT1));
        rel = 4'b0100;
        step();
        rel = '0;
        chk("nrel.e3.gnt", 8'(gnt), 8'h02);
        step();
        rel = 4'b0010;
        req = 4'b0101;
        step();
        rel = '0;
        chk("combo.gap.gnt", 8'(gnt), 8'h00);
        chk("combo.gap.busy", 8'(busy), 8'h01);
        step();
        chk("combo.idle.busy", 8'(busy), 8'h00);
        step();
        chk("combo.ptr2.gnt", 8'(gnt), 8'h04);

        // Reset mid-tenure with a nonzero pointer; first arbitration favours 0.
        req = 4'b0000;
        step();
        chk("drop.gnt", 8'(gnt), 8'h00);
        step();
        req = 4'b0010;
        step();
        chk("pre_rst.gnt", 8'(gnt), 8'h02);
        reset = 1'b1;
        step();
        chk_all_zero("mid_rst");
        reset = 1'b0;
        req   = 4'b1111;
        step();
        chk("post_rst.gnt", 8'(gnt), 8'h01);
        chk("post_rst.rled", 8'(rled), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
